// File: rtl/switchbox_pkg.sv
// Shared types and helpers for the switch-box configuration loader.
package switchbox_pkg;

  localparam int CONFIG_W_DEF = 60;
  localparam int SIDE_W       = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_PAR    = 3'd3,
    S_COMMIT = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // Lowest bit of box `box` inside the concatenated SRAM image bus.
  function automatic int slice_lo(input int box, input int width);
    return box * width;
  endfunction

endpackage

// File: rtl/switchbox_cfg_loader_shift_reg.sv
// LSB-first shadow register: bits enter at the top and settle so the first
// accepted bit ends up in q[0] once DATA_W bits have been shifted in.
module cfg_shift_reg
  import switchbox_pkg::*;
#(
  parameter int DATA_W = CONFIG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      q <= '0;
    end else if (load_en) begin
      q <= {bit_in, q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Framed bit-serial configuration loader for an array of switch boxes.
// Optional even-parity trailer bit is enabled by defining CFG_LOADER_PARITY_EN.
module switchbox_cfg_loader
  import switchbox_pkg::*;
#(
  parameter int CONFIG_W = CONFIG_W_DEF,
  parameter int N_BOX    = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic                      cfg_bit,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic [CONFIG_W*N_BOX-1:0] inp_sram,
  output logic [N_BOX-1:0]          box_en
);

  localparam int CNT_W = $clog2(CONFIG_W + 1);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(CONFIG_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [CONFIG_W-1:0] shadow;
  logic                bit_acc;
  logic                restart;
  logic                addr_ok;
`ifdef CFG_LOADER_PARITY_EN
  logic                par_acc;
`endif

  assign bit_acc = cfg_valid && cfg_ready;
  // A start pulse during COMMIT is ignored so the commit always completes.
  assign restart = cfg_start && (state != S_COMMIT);
  assign addr_ok = ({1'b0, addr_q} < (ADDR_W + 1)'(N_BOX));

  cfg_shift_reg #(
    .DATA_W(CONFIG_W)
  ) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .clr    (restart),
    .load_en(bit_acc && (state == S_DATA)),
    .bit_in (cfg_bit),
    .q      (shadow)
  );

  // Outputs are registered together with the state they describe.
  task automatic enter(input state_t s);
    state     <= s;
    cfg_ready <= (s == S_ADDR) || (s == S_DATA) || (s == S_PAR);
    cfg_busy  <= (s == S_ADDR) || (s == S_DATA) || (s == S_PAR) || (s == S_COMMIT);
  endtask

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      bit_cnt   <= '0;
      addr_q    <= '0;
      inp_sram  <= '0;
      box_en    <= '0;
`ifdef CFG_LOADER_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else begin
      cfg_done <= 1'b0;
      if (restart) begin
        enter(S_ADDR);
        cfg_err <= 1'b0;
        bit_cnt <= '0;
        addr_q  <= '0;
`ifdef CFG_LOADER_PARITY_EN
        par_acc <= 1'b0;
`endif
      end else begin
        case (state)
          S_ADDR: if (bit_acc) begin
            addr_q <= (addr_q >> 1) | (ADDR_W'(cfg_bit) << (ADDR_W - 1));
`ifdef CFG_LOADER_PARITY_EN
            par_acc <= par_acc ^ cfg_bit;
`endif
            if (bit_cnt == LAST_ADDR) begin
              enter(S_DATA);
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_DATA: if (bit_acc) begin
`ifdef CFG_LOADER_PARITY_EN
            par_acc <= par_acc ^ cfg_bit;
`endif
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef CFG_LOADER_PARITY_EN
              enter(S_PAR);
`else
              enter(S_COMMIT);
              cfg_done <= addr_ok;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef CFG_LOADER_PARITY_EN
          S_PAR: if (bit_acc) begin
            if (par_acc ^ cfg_bit) begin
              enter(S_ERR);
              cfg_err <= 1'b1;
            end else begin
              enter(S_COMMIT);
              cfg_done <= addr_ok;
            end
          end
`endif
          S_COMMIT: begin
            if (addr_ok) begin
              for (int k = 0; k < N_BOX; k++) begin
                if ({1'b0, addr_q} == (ADDR_W + 1)'(k)) begin
                  inp_sram[slice_lo(k, CONFIG_W) +: CONFIG_W] <= shadow;
                  box_en[k] <= 1'b1;
                end
              end
              enter(S_IDLE);
            end else begin
              cfg_err <= 1'b1;
              enter(S_ERR);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Directed bench for switchbox_cfg_loader with three boxes (addr 3 is out of range).
module tb_switchbox_cfg_loader;

  localparam int CW = 60;
  localparam int NB = 3;
  localparam int AW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_start;
  logic             cfg_bit;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;
  logic [CW*NB-1:0] inp_sram;
  logic [NB-1:0]    box_en;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_base;

  localparam logic [CW-1:0] GOOD_DATA = 60'h000000014011111;
  localparam logic [CW-1:0] ONES      = {CW{1'b1}};

  logic [CW*NB-1:0] exp_sram;

  switchbox_cfg_loader #(
    .CONFIG_W(CW),
    .N_BOX   (NB),
    .ADDR_W  (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_start(cfg_start),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .inp_sram (inp_sram),
    .box_en   (box_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) done_cnt <= done_cnt + int'(cfg_done);

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    cfg_valid = 1'b0;
    repeat (gap) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Start pulse, address, n_data data bits, and the parity bit for full frames.
  task automatic send_frame(input logic [AW-1:0] a, input logic [CW-1:0] d,
                            input int n_data, input int gap, input logic par_flip);
    logic par;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    par = par_flip;
    for (int i = 0; i < AW; i++) begin
      send_bit(a[i], gap);
      par = par ^ a[i];
    end
    for (int i = 0; i < n_data; i++) begin
      send_bit(d[i], gap);
      par = par ^ d[i];
    end
`ifdef CFG_LOADER_PARITY_EN
    if (n_data == CW) send_bit(par, gap);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    cfg_start = 1'b0;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_sram",  inp_sram,  '0);
    check_val("rst_en",    box_en,    '0);
    check_val("rst_ready", cfg_ready, 0);
    check_val("rst_busy",  cfg_busy,  0);
    check_val("rst_err",   cfg_err,   0);

    // Good frame to box 2
    send_frame(2'd2, GOOD_DATA, CW, 0, 1'b0);
    check_val("good_done_pulse", cfg_done,  1);
    check_val("good_busy_commit", cfg_busy, 1);
    check_val("good_ready_commit", cfg_ready, 0);
    @(negedge clk);
    check_val("good_done_low", cfg_done, 0);
    check_val("good_busy_idle", cfg_busy, 0);
    check_val("good_en", box_en, 3'b100);
    exp_sram = {GOOD_DATA, {CW{1'b0}}, {CW{1'b0}}};
    check_val("good_sram", inp_sram, exp_sram);

    // Stalled frame aborted after data bit 30, then a fresh all-ones frame
    done_base = done_cnt;
    send_frame(2'd1, 60'h0F0F0F0F0F0F0F0, 31, 3, 1'b0);
    check_val("stall_busy", cfg_busy, 1);
    check_val("stall_ready", cfg_ready, 1);
    check_val("stall_sram_untouched", inp_sram, exp_sram);
    send_frame(2'd1, ONES, CW, 3, 1'b0);
    check_val("abort_done_pulse", cfg_done, 1);
    @(negedge clk);
    exp_sram = {GOOD_DATA, ONES, {CW{1'b0}}};
    check_val("abort_sram", inp_sram, exp_sram);
    check_val("abort_en", box_en, 3'b110);
    check_val("abort_done_count", done_cnt - done_base, 1);

    // Out-of-range address
    send_frame(2'd3, 60'h00000000DEADBEEF, CW, 0, 1'b0);
    check_val("oor_no_done", cfg_done, 0);
    @(negedge clk);
    check_val("oor_err", cfg_err, 1);
    check_val("oor_busy", cfg_busy, 0);
    check_val("oor_ready", cfg_ready, 0);
    check_val("oor_en", box_en, 3'b110);
    check_val("oor_sram", inp_sram, exp_sram);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check_val("oor_err_cleared", cfg_err, 0);
    check_val("oor_restart_ready", cfg_ready, 1);

    // Reset asserted while data bit 20 is presented
    send_frame(2'd0, ONES, 20, 0, 1'b0);
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    reset     = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_sram", inp_sram, '0);
    check_val("midrst_en", box_en, '0);
    check_val("midrst_busy", cfg_busy, 0);
    check_val("midrst_ready", cfg_ready, 0);
    check_val("midrst_err", cfg_err, 0);

`ifdef CFG_LOADER_PARITY_EN
    send_frame(2'd0, 60'h1, CW, 0, 1'b1);
    check_val("par_bad_err", cfg_err, 1);
    check_val("par_bad_done", cfg_done, 0);
    @(negedge clk);
    check_val("par_bad_en", box_en, '0);
    check_val("par_bad_sram", inp_sram, '0);
`endif
    send_frame(2'd0, 60'h1, CW, 0, 1'b0);
    check_val("box0_done", cfg_done, 1);
    @(negedge clk);
    check_val("box0_err", cfg_err, 0);
    check_val("box0_en", box_en, 3'b001);
    check_val("box0_sram", inp_sram, {{CW{1'b0}}, {CW{1'b0}}, 60'h1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/switchbox_cfg_loader.md
Name: switchbox_cfg_loader

Overview:
Serial configuration controller for an array of switch boxes. It receives framed, bit-serial configuration streams and routes each frame by address. Each frame is assembled in a shadow register, then committed atomically into the addressed box's CONFIG_W-bit SRAM image. Per-box enable flags are held low until a box has a valid configuration, so an unconfigured box never drives its bidirectional side pins.

Parameters:
CONFIG_W, 60, SRAM bits per switch box (12 bits per side pin group x 5 pins).
N_BOX, 4, number of switch boxes served.
ADDR_W, 2, frame address width; must satisfy 2**ADDR_W >= N_BOX.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
cfg_start  in  1  one-cycle pulse that begins a frame.
cfg_bit  in  1  serial data bit, LSB first.
cfg_valid  in  1  cfg_bit is valid this cycle.
cfg_ready  out  1  loader accepts a bit this cycle.
cfg_busy  out  1  high while a frame is in progress (ADDR, DATA, PAR or COMMIT).
cfg_done  out  1  one-cycle pulse on successful commit.
cfg_err  out  1  sticky frame error flag.
inp_sram  out  CONFIG_W*N_BOX  concatenated SRAM images; box k occupies [k*CONFIG_W +: CONFIG_W].
box_en  out  N_BOX  box k holds a committed configuration.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; inp_sram=0, box_en=0, shadow=0, counters=0; cfg_ready=0, cfg_busy=0, cfg_done=0, cfg_err=0. Reset wins over every other event.
- A bit is accepted when cfg_valid && cfg_ready are both high at a clk edge. While cfg_valid=0, the FSM stalls and holds all state.
- cfg_ready=1 only in the ADDR, DATA and PAR states.
- IDLE: cfg_start -> ADDR. This clears cfg_err, bit_cnt and shadow.
- ADDR: accept ADDR_W bits LSB first into addr_q. After the last bit -> DATA.
- DATA: accept CONFIG_W bits; bit i is written to shadow[i]. After bit CONFIG_W-1 -> PAR if the optional feature is compiled in, otherwise -> COMMIT.
- COMMIT (one cycle, cfg_ready=0):
  - If addr_q < N_BOX: write shadow into the inp_sram slice, set box_en[addr_q], pulse cfg_done, then -> IDLE.
  - If addr_q >= N_BOX: set cfg_err, leave inp_sram and box_en unchanged, then -> ERR.
- ERR: cfg_busy=0, cfg_err=1. Only cfg_start exits, going -> ADDR with cfg_err cleared.
- Latency: cfg_done is high in the cycle after the last accepted bit. A full frame is ADDR_W+CONFIG_W(+1) accepted bits plus 1 cycle.
- cfg_start outside IDLE/ERR: abort the current frame, discard the shadow, clear counters, -> ADDR. Committed images are untouched. cfg_start has priority over a coincident bit accept; that bit is dropped.
- cfg_start in COMMIT: the commit completes first; cfg_start is ignored. Requesters must wait for cfg_done.
- Other slices of inp_sram are never disturbed by a commit. Re-committing the same address overwrites that slice in full.
- bit_cnt is sized $clog2(CONFIG_W+1). It never wraps inside a frame and resets on each state entry.

Optional Feature:
CFG_LOADER_PARITY_EN.
- Defined: a PAR state follows DATA and accepts one bit. Even parity over addr+data+parity bit is required, i.e. the XOR of all accepted bits must be 0. On mismatch, set cfg_err and go -> ERR without committing. On match, go -> COMMIT.
- Undefined: no PAR state exists and the frame is ADDR_W+CONFIG_W bits.

Decomposition:
- Shared package switchbox_pkg holds:
  - CONFIG_W_DEF=60, SIDE_W=5;
  - state encoding localparams S_IDLE, S_ADDR, S_DATA, S_PAR, S_COMMIT, S_ERR;
  - the slice-index function.
- One natural sub-module, cfg_shift_reg: a CONFIG_W-bit LSB-first shift/write register with clear and load-enable, used as the shadow.
- FSM and commit logic stay in the top.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> inp_sram=0, box_en=4'b0000, cfg_ready=0, cfg_err=0.
- Good frame: cfg_start, addr=2, data with bits 0,4,8,12,16,26,28 set, all valid. Expected:
  - cfg_done is high exactly 1 cycle after the last bit;
  - inp_sram[179:120]=60'h000000014011111;
  - box_en=4'b0100;
  - other slices remain 0.
- Stall and abort: frame to addr 1 with cfg_valid gaps of 3 cycles, then cfg_start after data bit 30 and a fresh frame addr 1 data=60'hFFFFFFFFFFFFFFF. Expected: only the second frame lands, inp_sram[119:60]=all ones, 1 cfg_done pulse.
- Out-of-range address with N_BOX=3: addr=3 -> cfg_err=1, state ERR, inp_sram/box_en unchanged. The next cfg_start clears cfg_err.
- Reset mid-frame: reset=0 during DATA bit 20 -> all outputs return to reset values, including previously committed slices and box_en.
- With CFG_LOADER_PARITY_EN: addr=0, data=60'h1, parity bit 0 -> cfg_err=1, no commit. The same frame with parity 1 -> cfg_done pulse and inp_sram[59:0]=60'h1.
